// File: rtl/rca2_pkg.sv
// rtl/rca2_pkg.sv - shared types and golden full-adder model for the RCA BIST controller
package rca2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_APPLY,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam logic [2:0] VEC_LAST = 3'd7;
  localparam int         NSLICE   = 4;

  // Returns {cout, sum}
  function automatic logic [1:0] fa_golden(input logic a, input logic b, input logic cin);
    return {(a & b) | (a & cin) | (b & cin), a ^ b ^ cin};
  endfunction

endpackage

// File: rtl/rca2_slice_cmp.sv
// rtl/rca2_slice_cmp.sv - compares every slice against the golden full adder for one vector
module rca2_slice_cmp #(
  parameter int NSLICE = 4
) (
  input  logic                a,
  input  logic                b,
  input  logic                cin,
  input  logic [NSLICE-1:0]   slice_sum,
  input  logic [NSLICE-1:0]   slice_cout,
  output logic [2*NSLICE-1:0] comp
);
  import rca2_pkg::*;

  logic [1:0] gold;

  assign gold = fa_golden(a, b, cin);
  // Carry mismatches occupy the upper half, sum mismatches the lower half
  assign comp = {slice_cout ^ {NSLICE{gold[1]}}, slice_sum ^ {NSLICE{gold[0]}}};

endmodule

// File: rtl/rca2_bist_ctrl.sv
// rtl/rca2_bist_ctrl.sv - exhaustive full-adder BIST sequencer producing comp/test for the select generator
module rca2_bist_ctrl #(
  parameter int NSLICE = 4,
  parameter int SETTLE = 2
) (
  input  logic                clk,
  input  logic                init,
  input  logic                start,
  output logic [NSLICE-1:0]   slice_a,
  output logic [NSLICE-1:0]   slice_b,
  output logic [NSLICE-1:0]   slice_cin,
  input  logic [NSLICE-1:0]   slice_sum,
  input  logic [NSLICE-1:0]   slice_cout,
  output logic                sel_init,
  output logic                test,
  output logic [2*NSLICE-1:0] comp,
  output logic [2*NSLICE-1:0] fault_map,
  output logic [3:0]          err_cnt,
  output logic                busy,
  output logic                done,
  output logic                fail
);
  import rca2_pkg::*;

  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

  state_t              state;
  logic [2:0]          vec;
  logic [2:0]          vec_next;
  logic [3:0]          settle_cnt;
  logic [2*NSLICE-1:0] cmp_now;

  assign vec_next = vec + 3'd1;

  rca2_slice_cmp #(.NSLICE(NSLICE)) u_cmp (
    .a          (vec[2]),
    .b          (vec[1]),
    .cin        (vec[0]),
    .slice_sum  (slice_sum),
    .slice_cout (slice_cout),
    .comp       (cmp_now)
  );

  always_ff @(posedge clk) begin
    if (init) begin
      state      <= ST_IDLE;
      vec        <= '0;
      settle_cnt <= '0;
      slice_a    <= '0;
      slice_b    <= '0;
      slice_cin  <= '0;
      sel_init   <= 1'b0;
      test       <= 1'b0;
      comp       <= '0;
      fault_map  <= '0;
      err_cnt    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state     <= ST_CLEAR;
            sel_init  <= 1'b1;
            vec       <= '0;
            slice_a   <= '0;
            slice_b   <= '0;
            slice_cin <= '0;
            fault_map <= '0;
            err_cnt   <= '0;
            fail      <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
          end
        end
        ST_CLEAR: begin
          state      <= ST_APPLY;
          sel_init   <= 1'b0;
          settle_cnt <= '0;
          slice_a    <= {NSLICE{vec[2]}};
          slice_b    <= {NSLICE{vec[1]}};
          slice_cin  <= {NSLICE{vec[0]}};
        end
        ST_APPLY: begin
          // Slice outputs are sampled only on the final settle edge
          if (settle_cnt == SETTLE_M1) begin
            state <= ST_CHECK;
            test  <= 1'b1;
            comp  <= cmp_now;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        ST_CHECK: begin
          test       <= 1'b0;
          comp       <= '0;
          settle_cnt <= '0;
          fault_map  <= fault_map | comp;
          fail       <= |(fault_map | comp);
          if (|comp) err_cnt <= err_cnt + 4'd1;
          if (vec == VEC_LAST) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state     <= ST_APPLY;
            vec       <= vec_next;
            slice_a   <= {NSLICE{vec_next[2]}};
            slice_b   <= {NSLICE{vec_next[1]}};
            slice_cin <= {NSLICE{vec_next[0]}};
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rca2_bist_ctrl.sv
// tb/tb_rca2_bist_ctrl.sv - scoreboard bench for rca2_bist_ctrl with stuck-at slice faults
module tb_rca2_bist_ctrl;
  localparam int SETTLE = 2;

  logic       clk = 1'b0;
  logic       init = 1'b1;
  logic       start = 1'b0;
  logic [3:0] slice_a, slice_b, slice_cin, slice_sum, slice_cout;
  logic       sel_init, test, busy, done, fail;
  logic [7:0] comp, fault_map;
  logic [3:0] err_cnt;

  logic [3:0] sum_sa0 = '0, sum_sa1 = '0, cout_sa0 = '0, cout_sa1 = '0;

  int checks = 0, errors = 0;
  int cyc = 0;
  int tests_seen = 0, sel_seen = 0, sel_cyc = 0;
  bit sel_pending = 1'b0, prev_test = 1'b0;
  logic [10:0] sb_q[$];
  logic [10:0] sb_e;

  rca2_bist_ctrl #(.NSLICE(4), .SETTLE(SETTLE)) dut (
    .clk        (clk),
    .init       (init),
    .start      (start),
    .slice_a    (slice_a),
    .slice_b    (slice_b),
    .slice_cin  (slice_cin),
    .slice_sum  (slice_sum),
    .slice_cout (slice_cout),
    .sel_init   (sel_init),
    .test       (test),
    .comp       (comp),
    .fault_map  (fault_map),
    .err_cnt    (err_cnt),
    .busy       (busy),
    .done       (done),
    .fail       (fail)
  );

  // Adder slices under test, with stuck-at fault injection
  assign slice_sum  = ((slice_a ^ slice_b ^ slice_cin) | sum_sa1) & ~sum_sa0;
  assign slice_cout = (((slice_a & slice_b) | (slice_a & slice_cin) | (slice_b & slice_cin))
                       | cout_sa1) & ~cout_sa0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sel_init) begin
      sel_seen++;
      sel_cyc = cyc;
      sel_pending = 1'b1;
    end
    if (test) begin
      tests_seen++;
      chk("test_gap", 32'(prev_test), 0);
      chk("busy_not_done", {busy, done}, 2'b10);
      if (sel_pending) begin
        chk("sel_to_test", cyc - sel_cyc, SETTLE + 1);
        sel_pending = 1'b0;
      end
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: test with comp=%h but no expected entry", comp);
      end else begin
        sb_e = sb_q.pop_front();
        chk("comp", comp, sb_e[7:0]);
        chk("vec", {slice_a[0], slice_b[0], slice_cin[0]}, sb_e[10:8]);
        chk("same_stim", {slice_a, slice_b, slice_cin},
            {{4{slice_a[0]}}, {4{slice_b[0]}}, {4{slice_cin[0]}}});
      end
    end
    prev_test = test;
  end

  // tbl holds the expected comp for vector v in byte v
  task automatic run(input logic [63:0] tbl, input bit poke,
                     input logic [3:0] exp_err, input logic [7:0] exp_map);
    int k;
    bit got;
    for (int v = 0; v < 8; v++) sb_q.push_back({3'(v), tbl[8*v +: 8]});
    tests_seen = 0;
    sel_seen = 0;
    start = 1'b1;
    @(negedge clk);
    k = cyc;
    start = 1'b0;
    chk("clear_sel_init", 32'(sel_init), 1);
    chk("clear_map_cnt", {fault_map, err_cnt}, 0);
    chk("clear_busy_done", {busy, done}, 2'b10);
    if (poke) begin
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
        @(negedge clk);
        got = test;
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = done;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: done low after 60 cycles, expected high");
    end else begin
      // CLEAR is cycle k+1, so done in cycle k+26 is 25 edges after the start edge
      chk("done_latency", cyc - k, 8 * (SETTLE + 1) + 1);
    end
    chk("test_count", tests_seen, 8);
    chk("sel_count", sel_seen, 1);
    chk("err_cnt", err_cnt, exp_err);
    chk("fault_map", fault_map, exp_map);
    chk("fail", 32'(fail), 32'(|exp_map));
  endtask

  initial begin
    int k;
    init = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_slices", {slice_a, slice_b, slice_cin}, 0);
    chk("rst_ctrl", {sel_init, test, comp, fault_map, err_cnt, busy, done, fail}, 0);
    init = 1'b0;
    @(negedge clk);

    // Fault-free run with a start pulse landing in a CHECK cycle
    run(64'h0, 1'b1, 4'd0, 8'h00);

    // Slice 2 sum stuck-at-0: odd-parity vectors 1, 2, 4, 7 mismatch
    sum_sa0 = 4'b0100;
    run(64'h04000004_00040400, 1'b0, 4'd4, 8'h04);

    // Restart from DONE with healthy slices
    sum_sa0 = 4'b0000;
    run(64'h0, 1'b0, 4'd0, 8'h00);

    // Slice 1 cout stuck-at-1 plus slice 3 sum stuck-at-1
    cout_sa1 = 4'b0010;
    sum_sa1  = 4'b1000;
    run(64'h00080820_08202028, 1'b0, 4'd7, 8'h28);
    cout_sa1 = 4'b0000;
    sum_sa1  = 4'b0000;

    // Reset in the first APPLY cycle of vector 3
    for (int v = 0; v < 3; v++) sb_q.push_back({3'(v), 8'h00});
    start = 1'b1;
    @(negedge clk);
    k = cyc;
    start = 1'b0;
    while (cyc < k + 10) @(negedge clk);
    chk("midrun_vec3", {slice_a[0], slice_b[0], slice_cin[0], busy}, 4'b0111);
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    chk("init_slices", {slice_a, slice_b, slice_cin}, 0);
    chk("init_ctrl", {sel_init, test, comp, fault_map, err_cnt, busy, done, fail}, 0);
    chk("init_sb_drained", sb_q.size(), 0);
    repeat (4) @(negedge clk);
    chk("idle_holds", {busy, done, test, sel_init}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded 100000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
